// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
//   XLEN          : data/address width of the memory port
//   write_width_t : store width; WW_BYTE is the idle/default value
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WW_BYTE = 2'd0,
        WW_HALF = 2'd1,
        WW_WORD = 2'd2
    } write_width_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single data-memory port between the pipeline memory stage (core)
// and the program-loader/debug DMA (dma). Core has default priority; a streak
// counter forces a DMA grant after MAX_CORE_STREAK consecutive core grants
// while DMA is waiting. Load data comes back one cycle after the grant and is
// steered to its owner through a registered {owner, is_load} tag.
//
// Optional feature, macro MEM_ARB_DMA_LOCK_EN: adds input dma_lock. A DMA grant
// with dma_lock=1 locks the port for DMA until dma_lock drops.
//
// Ports:
//   clock, reset_n              clock, synchronous active-low reset
//   core_req/addr/w_data/w_width/w_enable   core request fields
//   core_gnt, core_r_valid      core accept, core load data valid on rsp_data
//   dma_req/addr/w_data/w_width/w_enable    DMA request fields
//   dma_lock                    (MEM_ARB_DMA_LOCK_EN only) hold the port for DMA
//   dma_gnt, dma_r_valid        DMA accept, DMA load data valid on rsp_data
//   rsp_data                    load data shared by both requesters
//   mem_addr/w_data/w_width/w_enable        to memory block
//   mem_r_data                  from memory block, one cycle after address
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CORE_STREAK = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               core_req,
    input  logic [XLEN-1:0]    core_addr,
    input  logic [XLEN-1:0]    core_w_data,
    input  write_width_t       core_w_width,
    input  logic               core_w_enable,
    output logic               core_gnt,
    output logic               core_r_valid,
    input  logic               dma_req,
    input  logic [XLEN-1:0]    dma_addr,
    input  logic [XLEN-1:0]    dma_w_data,
    input  write_width_t       dma_w_width,
    input  logic               dma_w_enable,
`ifdef MEM_ARB_DMA_LOCK_EN
    input  logic               dma_lock,
`endif
    output logic               dma_gnt,
    output logic               dma_r_valid,
    output logic [XLEN-1:0]    rsp_data,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_w_data,
    output write_width_t       mem_w_width,
    output logic               mem_w_enable,
    input  logic [XLEN-1:0]    mem_r_data
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_CORE_STREAK);

    logic [3:0] streak_q, streak_d;
    logic       tag_load_q;
    logic       tag_owner_q;   // 1 = DMA owns the outstanding response
    logic       lock_active;
    logic       dma_wins;

`ifdef MEM_ARB_DMA_LOCK_EN
    // state      | meaning
    // ARB_NORMAL | core-priority arbitration with streak bound
    // ARB_LOCKED | DMA holds the port while dma_lock stays high
    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t state_q, state_d;

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ARB_NORMAL;
        else          state_q <= state_d;
    end

    // Dropping dma_lock releases the lock in the same cycle.
    assign lock_active = (state_q == ARB_LOCKED) && dma_lock;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_NORMAL: if (dma_gnt && dma_lock) state_d = ARB_LOCKED;
            ARB_LOCKED: if (!dma_lock)           state_d = ARB_NORMAL;
            default:                             state_d = ARB_NORMAL;
        endcase
    end
`else
    assign lock_active = 1'b0;
`endif

    assign dma_wins = dma_req && (lock_active || !core_req || (streak_q == STREAK_MAX));
    assign dma_gnt  = reset_n && dma_wins;
    assign core_gnt = reset_n && core_req && !dma_wins && !lock_active;

    always_comb begin
        streak_d = streak_q;
        if (!lock_active) begin
            if (dma_gnt || !dma_req)
                streak_d = 4'd0;
            else if (core_gnt && (streak_q != STREAK_MAX))
                streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            streak_q    <= 4'd0;
            tag_load_q  <= 1'b0;
            tag_owner_q <= 1'b0;
        end else begin
            streak_q    <= streak_d;
            tag_load_q  <= (core_gnt && !core_w_enable) || (dma_gnt && !dma_w_enable);
            tag_owner_q <= dma_gnt;
        end
    end

    // Gating with reset_n drops a response that was pending when reset asserted.
    assign core_r_valid = reset_n && tag_load_q && !tag_owner_q;
    assign dma_r_valid  = reset_n && tag_load_q &&  tag_owner_q;
    assign rsp_data     = (core_r_valid || dma_r_valid) ? mem_r_data : '0;

    always_comb begin
        mem_addr     = '0;
        mem_w_data   = '0;
        mem_w_width  = WW_BYTE;
        mem_w_enable = 1'b0;
        if (core_gnt) begin
            mem_addr     = core_addr;
            mem_w_data   = core_w_data;
            mem_w_width  = core_w_width;
            mem_w_enable = core_w_enable;
        end else if (dma_gnt) begin
            mem_addr     = dma_addr;
            mem_w_data   = dma_w_data;
            mem_w_width  = dma_w_width;
            mem_w_enable = dma_w_enable;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MAX = 4;
`ifdef MEM_ARB_DMA_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clock;
    logic            reset_n;
    logic            core_req, core_w_enable, core_gnt, core_r_valid;
    logic [XLEN-1:0] core_addr, core_w_data;
    write_width_t    core_w_width;
    logic            dma_req, dma_w_enable, dma_gnt, dma_r_valid;
    logic [XLEN-1:0] dma_addr, dma_w_data;
    write_width_t    dma_w_width;
    logic            dma_lock;
    logic [XLEN-1:0] rsp_data, mem_addr, mem_w_data, mem_r_data;
    write_width_t    mem_w_width;
    logic            mem_w_enable;

    mem_port_arbiter #(.MAX_CORE_STREAK(MAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .core_req(core_req), .core_addr(core_addr), .core_w_data(core_w_data),
        .core_w_width(core_w_width), .core_w_enable(core_w_enable),
        .core_gnt(core_gnt), .core_r_valid(core_r_valid),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_w_data(dma_w_data),
        .dma_w_width(dma_w_width), .dma_w_enable(dma_w_enable),
`ifdef MEM_ARB_DMA_LOCK_EN
        .dma_lock(dma_lock),
`endif
        .dma_gnt(dma_gnt), .dma_r_valid(dma_r_valid), .rsp_data(rsp_data),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_width(mem_w_width),
        .mem_w_enable(mem_w_enable), .mem_r_data(mem_r_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: pending response owner (0 none, 1 core, 2 dma),
    // count of consecutive core wins while DMA waits, and lock flag.
    int m_streak = 0;
    bit m_locked = 1'b0;
    int m_pend   = 0;
    bit exp_core, exp_dma;
    int want_core = -1;   // directed expectation, -1 = none
    int want_dma  = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        bit la;
        logic [31:0] ea, ed;
        logic [1:0]  ew;
        logic        ee;
        #1;
        la = LOCK_EN && m_locked && (dma_lock === 1'b1);
        if (!reset_n) begin
            exp_core = 1'b0;
            exp_dma  = 1'b0;
        end else begin
            exp_dma  = dma_req && (la || !core_req || m_streak >= MAX);
            exp_core = core_req && !exp_dma && !la;
        end
        ea = 0; ed = 0; ew = 2'd0; ee = 1'b0;
        if (exp_core) begin
            ea = core_addr; ed = core_w_data; ew = core_w_width; ee = core_w_enable;
        end else if (exp_dma) begin
            ea = dma_addr; ed = dma_w_data; ew = dma_w_width; ee = dma_w_enable;
        end
        chk("core_gnt", 32'(core_gnt), 32'(exp_core));
        chk("dma_gnt", 32'(dma_gnt), 32'(exp_dma));
        chk("mem_addr", mem_addr, ea);
        chk("mem_w_data", mem_w_data, ed);
        chk("mem_w_width", 32'(mem_w_width), 32'(ew));
        chk("mem_w_enable", 32'(mem_w_enable), 32'(ee));
        chk("core_r_valid", 32'(core_r_valid), 32'(reset_n && m_pend == 1));
        chk("dma_r_valid", 32'(dma_r_valid), 32'(reset_n && m_pend == 2));
        chk("rsp_data", rsp_data, (reset_n && m_pend != 0) ? mem_r_data : 32'h0);
        if (want_core >= 0) chk("directed_core_gnt", 32'(core_gnt), 32'(want_core));
        if (want_dma >= 0)  chk("directed_dma_gnt", 32'(dma_gnt), 32'(want_dma));
        @(posedge clock);
        if (!reset_n) begin
            m_streak = 0;
            m_locked = 1'b0;
            m_pend   = 0;
        end else begin
            if (!la) begin
                if (exp_dma || !dma_req)
                    m_streak = 0;
                else if (exp_core && m_streak < MAX)
                    m_streak = m_streak + 1;
            end
            m_locked = LOCK_EN && (dma_lock === 1'b1) && (m_locked || exp_dma);
            if (exp_core && !core_w_enable)     m_pend = 1;
            else if (exp_dma && !dma_w_enable)  m_pend = 2;
            else                                m_pend = 0;
        end
        @(negedge clock);
    endtask

    task automatic set_core(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input write_width_t w, input logic we);
        core_req = r; core_addr = a; core_w_data = d; core_w_width = w; core_w_enable = we;
    endtask

    task automatic set_dma(input logic r, input logic [31:0] a, input logic [31:0] d,
                           input write_width_t w, input logic we);
        dma_req = r; dma_addr = a; dma_w_data = d; dma_w_width = w; dma_w_enable = we;
    endtask

    bit core_hold, dma_hold;

    initial begin
        reset_n = 1'b0;
        dma_lock = 1'b0;
        mem_r_data = 32'h0;
        set_core(1'b1, 32'h100, 32'h0, WW_WORD, 1'b0);
        set_dma(1'b1, 32'h200, 32'h0, WW_WORD, 1'b0);
        @(negedge clock);

        // Reset held 3 cycles with both requesting.
        for (int i = 0; i < 3; i++) begin
            mem_r_data = 32'hA5A5_0000 + 32'(i);
            cycle();
        end
        reset_n = 1'b1;
        want_core = 1;
        cycle();
        want_core = -1;

        // Core load, data returns next cycle.
        set_dma(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        set_core(1'b1, 32'h0002_0010, 32'h0, WW_WORD, 1'b0);
        cycle();
        set_core(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        mem_r_data = 32'hDEAD_BEEF;
        cycle();

        // Starvation bound: C,C,C,C,D repeating.
        set_core(1'b1, 32'h0000_0040, 32'h1111_1111, WW_WORD, 1'b1);
        set_dma(1'b1, 32'h0000_0080, 32'h2222_2222, WW_HALF, 1'b1);
        for (int i = 0; i < 12; i++) begin
            want_dma  = (i == 4 || i == 9) ? 1 : 0;
            want_core = (i == 4 || i == 9) ? 0 : 1;
            cycle();
        end
        want_core = -1; want_dma = -1;

        // DMA store with core idle, then no response.
        set_core(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        set_dma(1'b1, 32'h0002_0000, 32'h1234_5678, WW_WORD, 1'b1);
        want_dma = 1;
        cycle();
        want_dma = -1;
        set_dma(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        mem_r_data = 32'hFFFF_0000;
        cycle();

        // Interleaved loads: core in N, DMA in N+1.
        set_core(1'b1, 32'h0000_0104, 32'h0, WW_WORD, 1'b0);
        cycle();
        set_core(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        set_dma(1'b1, 32'h0000_0208, 32'h0, WW_WORD, 1'b0);
        mem_r_data = 32'hC0DE_0001;
        cycle();
        set_dma(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        mem_r_data = 32'hD0A0_0002;
        cycle();

        // Pending load dropped by reset.
        set_core(1'b1, 32'h0000_0300, 32'h0, WW_WORD, 1'b0);
        cycle();
        set_core(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        reset_n = 1'b0;
        mem_r_data = 32'hBAD0_BAD0;
        cycle();
        reset_n = 1'b1;
        cycle();

`ifdef MEM_ARB_DMA_LOCK_EN
        // Lock: DMA takes the port, then a 6-access burst against core_req.
        dma_lock = 1'b1;
        set_dma(1'b1, 32'h0000_0400, 32'h0, WW_WORD, 1'b1);
        want_dma = 1;
        cycle();
        set_core(1'b1, 32'h0000_0500, 32'h0, WW_WORD, 1'b0);
        want_core = 0;
        for (int i = 0; i < 6; i++) begin
            dma_addr = 32'h0000_0400 + 32'(4 * (i + 1));
            cycle();
        end
        dma_lock = 1'b0;
        set_dma(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        want_dma = 0;
        want_core = 1;
        cycle();
        want_core = -1; want_dma = -1;
        set_core(1'b0, 32'h0, 32'h0, WW_BYTE, 1'b0);
        cycle();
`endif

        // Randomized traffic obeying the hold-until-grant rule.
        core_hold = 1'b0;
        dma_hold  = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!core_hold)
                set_core(1'($urandom_range(0, 1)), $urandom, $urandom,
                         write_width_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 7) == 0)
                core_req = 1'b0;
            if (!dma_hold)
                set_dma(1'($urandom_range(0, 1)), $urandom, $urandom,
                        write_width_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            else if ($urandom_range(0, 7) == 0)
                dma_req = 1'b0;
            if (LOCK_EN)
                dma_lock = ($urandom_range(0, 3) != 0) ? dma_lock : ~dma_lock;
            reset_n = ($urandom_range(0, 99) != 0);
            mem_r_data = $urandom;
            cycle();
            core_hold = core_req && !exp_core;
            dma_hold  = dma_req && !exp_dma;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (address/write/read bus of the data memory + MMIO decode block) between two requesters: the pipeline memory stage (core) and the program-loader/debug DMA (dma).
- Sits between the requesters and the memory block.
- Core has default priority; a streak counter bounds DMA starvation. Read data returns one cycle after acceptance and is routed back to the owner via a registered tag.

Parameters:
- XLEN, 32, data/address width (package constant, not overridable per instance).
- MAX_CORE_STREAK, 4, consecutive core grants allowed while dma_req is pending before DMA is forced a grant; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- core_req  in  1  core requests a memory access this cycle.
- core_addr  in  XLEN  core byte address.
- core_w_data  in  XLEN  core store data.
- core_w_width  in  write_width_t  core store width.
- core_w_enable  in  1  1 = store, 0 = load.
- core_gnt  out  1  core access accepted this cycle.
- core_r_valid  out  1  rsp_data holds core load data.
- dma_req  in  1  DMA requests a memory access.
- dma_addr  in  XLEN  DMA byte address.
- dma_w_data  in  XLEN  DMA store data.
- dma_w_width  in  write_width_t  DMA store width.
- dma_w_enable  in  1  1 = store, 0 = load.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_r_valid  out  1  rsp_data holds DMA load data.
- rsp_data  out  XLEN  load data, shared by both requesters.
- mem_addr  out  XLEN  to memory block addr.
- mem_w_data  out  XLEN  to memory block w_data.
- mem_w_width  out  write_width_t  to memory block w_width.
- mem_w_enable  out  1  to memory block w_enable.
- mem_r_data  in  XLEN  from memory block r_data; valid the cycle after the address is presented.

Behaviour:
- Grants are combinational from the req inputs and registered state. At most one gnt is high per cycle. gnt high means the transaction is accepted in that cycle.
- Requesters hold req, addr, data, width and enable stable until gnt. Dropping req before gnt is legal, and the request is abandoned.
- mem_* carries the granted requester's fields. With no grant: mem_addr=0, mem_w_data=0, mem_w_width=reset/default enum value, mem_w_enable=0.
- Priority rule:
  - dma wins if dma_req and (!core_req or streak == MAX_CORE_STREAK).
  - Otherwise core wins if core_req.
- streak (4-bit register):
  - +1 on each core grant while dma_req=1, saturating at MAX_CORE_STREAK.
  - Cleared on any dma grant.
  - Cleared in any cycle with dma_req=0.
- Response tag: registered {owner, is_load}, set on every grant and cleared when there is no grant.
  - Next cycle: core_r_valid=1 iff the tag owner is core and the access was a load. dma_r_valid likewise.
  - Stores produce no r_valid.
- rsp_data = mem_r_data whenever either r_valid is high, else 0.
- Load-to-use latency: 1 cycle after gnt. Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.
- Reset (reset_n=0 at a clock edge):
  - streak, tag and lock state are cleared.
  - While reset_n=0: core_gnt=dma_gnt=0, mem_w_enable=0, r_valid=0.
  - A response pending when reset asserts is dropped (no r_valid after reset).
  - First grant is possible in the first cycle with reset_n=1.

Optional Feature:
- MEM_ARB_DMA_LOCK_EN. When defined:
  - Adds input port dma_lock (1 bit).
  - A DMA grant with dma_lock=1 enters state LOCKED.
  - While LOCKED, core_gnt=0 regardless of core_req, and streak is frozen.
  - LOCKED exits combinationally in any cycle where dma_lock=0; normal arbitration applies in that same cycle.
  - Reset clears LOCKED.
- When undefined: the port is absent and arbitration is always the normal rule.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with core_req=dma_req=1 -> both gnt=0, mem_w_enable=0, no r_valid; first cycle after release -> core_gnt=1.
- Core load: core_req=1, core_addr=0x00020010, core_w_enable=0, mem_r_data=0xDEADBEEF next cycle -> core_gnt=1 in cycle N; core_r_valid=1 and rsp_data=0xDEADBEEF in N+1; dma_r_valid=0.
- Starvation bound: core_req and dma_req held high for 12 cycles, MAX_CORE_STREAK=4 -> grant pattern C,C,C,C,D repeating (cycle 5 and cycle 10 are DMA grants).
- DMA store: dma_req=1, dma_w_enable=1, addr 0x00020000, data 0x12345678, core idle -> dma_gnt=1, mem_w_enable=1, mem_addr/mem_w_data match; no r_valid in the following cycle.
- Interleaved loads: core load in N, DMA load in N+1 -> core_r_valid in N+1, dma_r_valid in N+2, each with that cycle's mem_r_data.
- Lock (MEM_ARB_DMA_LOCK_EN defined): dma_lock=1 with a 6-access DMA burst while core_req=1 -> core_gnt=0 for all 6 cycles; dma_lock=0 in cycle 7 with dma_req=0 -> core_gnt=1 in cycle 7.
